// File: rtl/up_down_mon_pkg.sv
// Shared definitions for the up/down counter monitor.
//   CNT_W / REV_W : counter width and revolution-count width
//   REV_MAX/MIN   : saturation limits for the signed revolution count
//   state_t       : monitor FSM encoding (IDLE=0, ACQUIRE=1, TRACK=2, FAULT=3)
package up_down_mon_pkg;
    localparam int CNT_W = 3;
    localparam int REV_W = 8;
    localparam logic signed [REV_W-1:0] REV_MAX = 8'sh7f;  // +127
    localparam logic signed [REV_W-1:0] REV_MIN = 8'sh80;  // -128

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_FAULT   = 2'd3
    } state_t;
endpackage

// File: rtl/up_down_count_monitor_step_predict.sv
// step_predict: predicts the next counter value from the previous sample.
//   i_prev_q  : previously sampled counter value (index 0 is MSB)
//   i_prev_ud : direction sampled together with i_prev_q (1 = up)
//   o_exp     : expected current counter value, modulo 2**CNT_W
module step_predict
    import up_down_mon_pkg::*;
(
    input  logic [0:CNT_W-1] i_prev_q,
    input  logic             i_prev_ud,
    output logic [0:CNT_W-1] o_exp
);
    assign o_exp = i_prev_ud ? i_prev_q + CNT_W'(1) : i_prev_q - CNT_W'(1);
endmodule

// File: rtl/up_down_count_monitor.sv
// up_down_count_monitor: watches a 3-bit up/down counter, checks every step
// against the direction sampled with the previous value, counts net
// revolutions and captures the first mismatching step.
//   clk, clear     : clock, synchronous active-high reset
//   en             : monitor enable (0 forces IDLE)
//   ud, q          : counter direction and counter value (q[0] is MSB)
//   state          : FSM state; locked = TRACK, fault = FAULT
//   wrap_up/wrap_dn: one-cycle pulses on 7->0 (up) / 0->7 (down) steps
//   rev_cnt/rev_ovf: saturating signed revolution count and sticky overflow
//   exp_q/bad_q    : expected/observed value captured at the fault
module up_down_count_monitor
    import up_down_mon_pkg::*;
(
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    ud,
    input  logic [0:CNT_W-1]        q,
    output logic [1:0]              state,
    output logic                    locked,
    output logic                    fault,
    output logic                    wrap_up,
    output logic                    wrap_dn,
    output logic signed [REV_W-1:0] rev_cnt,
    output logic                    rev_ovf,
    output logic [0:CNT_W-1]        exp_q,
    output logic [0:CNT_W-1]        bad_q
);
    state_t                  r_state;
    logic [0:CNT_W-1]        r_prev_q;
    logic                    r_prev_ud;
    logic                    r_locked, r_fault, r_wrap_up, r_wrap_dn, r_ovf;
    logic signed [REV_W-1:0] r_rev;
    logic [0:CNT_W-1]        r_exp_q, r_bad_q;

    state_t                  w_next;
    logic [0:CNT_W-1]        w_exp;
    logic                    w_mismatch, w_wrap_up, w_wrap_dn;

    step_predict u_pred (
        .i_prev_q  (r_prev_q),
        .i_prev_ud (r_prev_ud),
        .o_exp     (w_exp)
    );

    // Next state plus TRACK-only step checks. Dropping en wins over
    // everything, including a mismatch or wrap seen on the same edge.
    always_comb begin
        w_next     = r_state;
        w_mismatch = 1'b0;
        w_wrap_up  = 1'b0;
        w_wrap_dn  = 1'b0;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:    w_next = S_ACQUIRE;
                S_ACQUIRE: w_next = S_TRACK;
                S_TRACK: begin
                    if (q != w_exp) begin
                        w_next     = S_FAULT;
                        w_mismatch = 1'b1;
                    end else begin
                        // Only a matching step can be a wrap.
                        w_wrap_up = r_prev_ud  && (r_prev_q == 3'd7) && (q == 3'd0);
                        w_wrap_dn = !r_prev_ud && (r_prev_q == 3'd0) && (q == 3'd7);
                    end
                end
                S_FAULT:   w_next = S_FAULT;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_prev_q  <= '0;
            r_prev_ud <= 1'b0;
            r_locked  <= 1'b0;
            r_fault   <= 1'b0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            r_rev     <= '0;
            r_ovf     <= 1'b0;
            r_exp_q   <= '0;
            r_bad_q   <= '0;
        end else begin
            r_state   <= w_next;
            r_prev_q  <= q;
            r_prev_ud <= ud;
            // Status flags follow the registered state.
            r_locked  <= (w_next == S_TRACK);
            r_fault   <= (w_next == S_FAULT);
            r_wrap_up <= w_wrap_up;
            r_wrap_dn <= w_wrap_dn;
            if (w_wrap_up) begin
                if (r_rev == REV_MAX) r_ovf <= 1'b1;
                else                  r_rev <= r_rev + REV_W'(1);
            end else if (w_wrap_dn) begin
                if (r_rev == REV_MIN) r_ovf <= 1'b1;
                else                  r_rev <= r_rev - REV_W'(1);
            end
            if (w_mismatch) begin
                r_exp_q <= w_exp;
                r_bad_q <= q;
            end
        end
    end

    assign state   = r_state;
    assign locked  = r_locked;
    assign fault   = r_fault;
    assign wrap_up = r_wrap_up;
    assign wrap_dn = r_wrap_dn;
    assign rev_cnt = r_rev;
    assign rev_ovf = r_ovf;
    assign exp_q   = r_exp_q;
    assign bad_q   = r_bad_q;
endmodule

// File: tb/tb_up_down_count_monitor.sv
module tb_up_down_count_monitor;
    logic       clk = 1'b0;
    logic       clear, en, ud;
    logic [0:2] q;
    logic [1:0] state;
    logic       locked, fault, wrap_up, wrap_dn, rev_ovf;
    logic [7:0] rev_cnt;
    logic [0:2] exp_q, bad_q;

    up_down_count_monitor dut (
        .clk(clk), .clear(clear), .en(en), .ud(ud), .q(q),
        .state(state), .locked(locked), .fault(fault),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn),
        .rev_cnt(rev_cnt), .rev_ovf(rev_ovf),
        .exp_q(exp_q), .bad_q(bad_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_step = 0;

    // Reference model state
    logic [1:0]        m_st;
    logic [2:0]        m_pq, m_eq, m_bq;
    logic              m_pud, m_ovf, m_wu, m_wd;
    logic signed [7:0] m_rev;
    logic [20:0]       sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [20:0] outv();
        return {state, locked, fault, wrap_up, wrap_dn, rev_cnt, rev_ovf, exp_q, bad_q};
    endfunction

    // Drive one cycle, push the model's expected outputs, then pop and compare.
    task automatic step(input logic c, input logic e, input logic d, input logic [2:0] qq);
        logic [2:0] ex;
        logic [1:0] nst;
        clear = c; en = e; ud = d; q = qq;
        ex = m_pud ? m_pq + 3'd1 : m_pq - 3'd1;
        m_wu = 1'b0; m_wd = 1'b0;
        if (c) begin
            m_st = 2'd0; m_pq = 3'd0; m_pud = 1'b0; m_rev = 8'sd0;
            m_ovf = 1'b0; m_eq = 3'd0; m_bq = 3'd0;
        end else begin
            nst = m_st;
            if (!e) nst = 2'd0;
            else if (m_st == 2'd0) nst = 2'd1;
            else if (m_st == 2'd1) nst = 2'd2;
            else if (m_st == 2'd2) begin
                if (qq != ex) begin
                    nst = 2'd3; m_eq = ex; m_bq = qq;
                end else if (m_pud && m_pq == 3'd7 && qq == 3'd0) begin
                    m_wu = 1'b1;
                    if (m_rev == 8'sh7f) m_ovf = 1'b1; else m_rev = m_rev + 8'sd1;
                end else if (!m_pud && m_pq == 3'd0 && qq == 3'd7) begin
                    m_wd = 1'b1;
                    if (m_rev == 8'sh80) m_ovf = 1'b1; else m_rev = m_rev - 8'sd1;
                end
            end
            m_st = nst; m_pq = qq; m_pud = d;
        end
        sb.push_back({m_st, m_st == 2'd2, m_st == 2'd3, m_wu, m_wd, m_rev, m_ovf, m_eq, m_bq});
        @(posedge clk); #1;
        chk($sformatf("step%0d", n_step), {11'd0, outv()}, {11'd0, sb.pop_front()});
        n_step++;
    endtask

    initial begin
        logic [2:0] cq;
        logic       pd;
        clear = 1'b1; en = 1'b0; ud = 1'b0; q = 3'd0;

        // Reset
        step(1, 0, 0, 3'd0);
        chk("reset_all", {11'd0, outv()}, 32'd0);

        // Up count with wrap
        step(0, 1, 1, 3'd5);
        chk("acquire_state", {30'd0, state}, 32'd1);
        step(0, 1, 1, 3'd6);
        chk("locked_third", {31'd0, locked}, 32'd1);
        step(0, 1, 1, 3'd7);
        step(0, 1, 1, 3'd0);
        chk("wrap_up_pulse", {31'd0, wrap_up}, 32'd1);
        chk("rev_one", {24'd0, rev_cnt}, 32'd1);
        step(0, 1, 0, 3'd1);  // direction changes here, step still checked as up
        chk("wrap_up_gone", {31'd0, wrap_up}, 32'd0);

        // Down count with wrap
        step(0, 1, 0, 3'd0);
        step(0, 1, 0, 3'd7);
        chk("wrap_dn_pulse", {31'd0, wrap_dn}, 32'd1);
        chk("rev_zero", {24'd0, rev_cnt}, 32'd0);
        step(0, 1, 0, 3'd6);
        chk("no_fault_dn", {31'd0, fault}, 32'd0);

        // Glitch 3 -> 5 while counting up
        step(1, 0, 0, 3'd0);
        step(0, 1, 1, 3'd2);
        step(0, 1, 1, 3'd3);
        step(0, 1, 1, 3'd5);
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("exp_q_cap", {29'd0, exp_q}, 32'd4);
        chk("bad_q_cap", {29'd0, bad_q}, 32'd5);
        chk("no_wrap_glitch", {30'd0, wrap_up, wrap_dn}, 32'd0);
        step(0, 1, 1, 3'd6);
        chk("fault_hold", {31'd0, fault}, 32'd1);
        step(0, 0, 1, 3'd7);
        chk("fault_to_idle", {30'd0, state}, 32'd0);
        chk("exp_q_held", {29'd0, exp_q}, 32'd4);

        // 130 up revolutions -> saturation
        step(1, 0, 0, 3'd0);
        step(0, 1, 1, 3'd0);
        step(0, 1, 1, 3'd1);
        cq = 3'd1;
        for (int i = 0; i < 130 * 8; i++) begin
            cq = cq + 3'd1;
            step(0, 1, 1, cq);
        end
        chk("rev_sat", {24'd0, rev_cnt}, 32'h7f);
        chk("rev_ovf_set", {31'd0, rev_ovf}, 32'd1);
        step(0, 0, 1, 3'd0);
        step(0, 1, 1, 3'd0);
        chk("rev_persist", {24'd0, rev_cnt}, 32'h7f);
        chk("ovf_persist", {31'd0, rev_ovf}, 32'd1);

        // Direction toggling every cycle
        step(1, 0, 0, 3'd0);
        step(0, 1, 1, 3'd3);
        cq = 3'd3; pd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cq = pd ? cq + 3'd1 : cq - 3'd1;
            pd = ~pd;
            step(0, 1, pd, cq);
        end
        chk("toggle_no_fault", {31'd0, fault}, 32'd0);
        chk("toggle_locked", {31'd0, locked}, 32'd1);

        // Clear on a 7->0 step mid-TRACK
        step(1, 0, 0, 3'd0);
        step(0, 1, 1, 3'd6);
        step(0, 1, 1, 3'd7);
        chk("pre_clear_track", {30'd0, state}, 32'd2);
        step(1, 1, 1, 3'd0);
        chk("clear_no_wrap", {31'd0, wrap_up}, 32'd0);
        chk("clear_all_zero", {11'd0, outv()}, 32'd0);
        step(0, 0, 0, 3'd1);
        chk("after_clear_zero", {11'd0, outv()}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/up_down_count_monitor.md
UP_DOWN_COUNT_MONITOR -- requirements
Module: up_down_count_monitor

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high, named clk and clear as in the rest of the codebase.
REQ-002 clk  input  1  rising-edge clock, the same clock that drives the 3-bit up/down counter.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 en  input  1  monitor enable; while 0, the block is forced to IDLE.
REQ-005 ud  input  1  counter direction, the same net that feeds the counter; 1 = up, 0 = down.
REQ-006 q  input  [0:2]  counter output; q[0] is the MSB.
REQ-007 state  output  2  current FSM state encoding.
REQ-008 locked  output  1  high while state = TRACK.
REQ-009 fault  output  1  high while state = FAULT.
REQ-010 wrap_up  output  1  one-cycle pulse on a 7->0 step while counting up.
REQ-011 wrap_dn  output  1  one-cycle pulse on a 0->7 step while counting down.
REQ-012 rev_cnt  output  8  signed two's-complement net revolution count.
REQ-013 rev_ovf  output  1  sticky flag, set when rev_cnt saturates.
REQ-014 exp_q  output  [0:2]  expected value captured at the fault.
REQ-015 bad_q  output  [0:2]  observed value captured at the fault.

Function
REQ-016 Sampling: every rising clk edge SHALL register prev_q <= q and prev_ud <= ud.
REQ-017 Expected value: exp = prev_q + 1 mod 8 when prev_ud = 1, and prev_q - 1 mod 8 when prev_ud = 0.
REQ-018 FSM states SHALL be IDLE = 0, ACQUIRE = 1, TRACK = 2, FAULT = 3.
REQ-019 Transitions:
- IDLE -> ACQUIRE when en = 1.
- ACQUIRE -> TRACK unconditionally after one cycle, which loads prev_q/prev_ud.
- TRACK -> FAULT when q != exp.
- FAULT holds until en = 0 or clear.
REQ-020 en = 0 SHALL force the next state to IDLE from any state; this takes priority over every other transition.
REQ-021 In TRACK with q == exp, the FSM SHALL stay in TRACK.
REQ-022 Comparison and wrap detection SHALL occur only in TRACK; in IDLE, ACQUIRE and FAULT, wrap_up and wrap_dn SHALL be 0 and rev_cnt SHALL hold.
REQ-023 wrap_up SHALL be registered: it is high for exactly the one cycle after the edge that sampled q = 0, given prev_q = 7, prev_ud = 1, in TRACK.
REQ-024 wrap_dn SHALL be the mirror case: q = 7, prev_q = 0, prev_ud = 0.
REQ-025 A wrap SHALL never be flagged on a mismatching step.
REQ-026 rev_cnt SHALL increment on wrap_up and decrement on wrap_dn.
REQ-027 rev_cnt SHALL saturate at +127 and -128; any wrap attempted at the limit SHALL leave rev_cnt unchanged and set rev_ovf.
REQ-028 rev_cnt and rev_ovf SHALL persist through IDLE and re-enable, and SHALL be cleared only by clear.
REQ-029 On the TRACK -> FAULT edge, exp_q <= exp and bad_q <= q; both SHALL hold until the next such event or clear.
REQ-030 A direction change is legal: the step is checked against the ud that was sampled with prev_q.

Reset
REQ-031 When clear = 1 at an edge, the block SHALL set state = IDLE, prev_q = 0, prev_ud = 0, rev_cnt = 0, rev_ovf = 0, exp_q = 0, bad_q = 0, wrap_up = 0 and wrap_dn = 0.
REQ-032 clear SHALL take priority over en and over any in-flight wrap or fault capture.
REQ-033 clear asserted mid-TRACK SHALL discard the pending comparison.

Structure
REQ-034 A shared package up_down_mon_pkg SHALL hold the state encodings, CNT_W = 3, REV_W = 8, REV_MAX = 127 and REV_MIN = -128.
REQ-035 The combinational expected-value function SHALL live in one sub-module, step_predict (prev_q, prev_ud -> exp).
REQ-036 All outputs SHALL be driven directly from flops.

Verification
REQ-037 clear, then en = 1, ud = 1, q stepping 5,6,7,0,1 -> locked from the third cycle, one wrap_up pulse after the q = 0 sample, rev_cnt = 1.
REQ-038 ud = 0, q stepping 1,0,7,6 in TRACK -> one wrap_dn pulse, rev_cnt returns to 0, no fault.
REQ-039 Forced glitch in TRACK, q goes 3 -> 5 with ud = 1 -> fault = 1, exp_q = 4, bad_q = 5, no wrap pulse; fault stays set until en = 0, then state = IDLE.
REQ-040 Continuous up counting for 130 revolutions -> rev_cnt = 127, rev_ovf = 1.
REQ-041 ud toggled every cycle, with q following correctly -> no fault; clear asserted mid-TRACK on a 7->0 step -> no wrap_up, all outputs at reset values on the next cycle.
